result_cl_writer: RTL and testbench
===================================

Name: result_cl_writer

Overview:
- Write-back engine for the filter-scan AFU. It packs 64-bit bit-vector results into 512-bit cache lines and issues CCI-P channel-1 WrLine_I requests to a host buffer.
- It counts write acknowledgements and raises done when every line has been committed.
- It sits between filter_scan_p64 results and af2cp_sTx.c1. The CSR block supplies the base address, start pulse and flush pulse.

Parameters:
- ADDR_W, 42, cache-line address width (matches t_ccip_clAddr)
- WORDS_PER_CL, 8, 64-bit result words per 512-bit line
- CNT_W, 16, width of line index and issue/ack counters
- FIFO_DEPTH, 4, completed lines buffered while c1TxAlmFull is asserted (power of 2)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- start  in  1  pulse: latch base_addr, clear counters, enter ACTIVE
- base_addr  in  ADDR_W  host write-buffer cache-line address
- flush  in  1  pulse: no more results; emit partial line; drain
- res_valid  in  1  result word valid
- res_data  in  64  bit-vector result word
- res_ready  out  1  result word accepted when res_valid && res_ready
- wr_almfull  in  1  c1TxAlmFull
- wr_ack  in  1  one pulse per completed write (c1Rx.rspValid, single-line)
- wr_valid  out  1  c1 write request valid (registered)
- wr_addr  out  ADDR_W  request cache-line address
- wr_mdata  out  16  request mdata = line index
- wr_data  out  512  line payload
- lines_issued  out  CNT_W  requests sent since start
- lines_acked  out  CNT_W  acks received since start
- busy  out  1  state is ACTIVE or DRAIN
- done  out  1  state is DONE
- err  out  1  sticky: start while busy, ack underflow, or index overflow

Behaviour:
- Reset values: all outputs 0, state IDLE, FIFO empty, pack buffer 0, word count 0.
- States:
  - IDLE -> ACTIVE on start.
  - ACTIVE -> DRAIN on flush.
  - DRAIN -> DONE when pack buffer empty, FIFO empty, no request in flight and lines_acked == lines_issued.
  - DONE -> ACTIVE on start.
- Start handling:
  - start in ACTIVE/DRAIN is ignored and sets err.
  - start in IDLE/DONE clears counters, pack buffer and err.
- res_ready = (state==ACTIVE) && FIFO occupancy < FIFO_DEPTH. It is combinational from registered state only and never depends on res_valid.
- Packing: accepted word k (0..7) is written to pack[64*k +: 64]. On the edge accepting word 7, the combinationally completed line is pushed to the FIFO and the pack buffer and word count clear.
- Flush:
  - Flush with word count > 0: the partial line, upper words zero, is pushed on the next edge at which the FIFO is not full.
  - Flush with word count == 0: no extra line.
  - Flush and accepted res_valid on the same edge: the word is included first, then the flush applies. If that word is word 7, the full line is pushed and no partial line follows.
- Issue:
  - Each edge: wr_valid <= busy && FIFO non-empty && !wr_almfull. Pop on the same edge.
  - wr_addr = base_addr + zero-extended line index.
  - wr_mdata = line index.
  - lines_issued increments on the pop edge.
  - Header is fixed by the wrapper: vc_sel eVC_VA, sop 1, cl_len eCL_LEN_1, req_type eREQ_WRLINE_I.
- Latency:
  - Word 7 accepted at edge N gives wr_valid high for the cycle after edge N+1, provided wr_almfull is low before N+1.
  - While wr_almfull is held, at most one already-registered request is visible.
- wr_valid is a one-cycle pulse per line. Back-to-back lines give consecutive pulses.
- Acks:
  - wr_ack increments lines_acked.
  - An ack when lines_acked == lines_issued sets err and does not increment.
  - Acks are counted in every state, including DONE.
- Overflow: lines_issued wraps modulo 2^CNT_W and sets err on wrap.
- reset mid-operation: immediate return to IDLE, FIFO discarded, wr_valid 0 the next cycle.

Decomposition:
- Package result_wr_pkg holds:
  - CL_WORDS
  - t_res_word (64b)
  - t_line (512b)
  - t_line_idx
  - t_wr_state enum {IDLE, ACTIVE, DRAIN, DONE}
- One sub-module: result_line_fifo. It is a parameterised synchronous FIFO of t_line plus t_line_idx, with push/pop/full/empty/count.

Test Plan:
- Basic line: start base 0x1000, 8 words 0x0..0x7, flush, ack after 5 cycles -> one wr_valid:
  - wr_addr 0x1000, mdata 0
  - word k at bits 64k
  - then done=1, lines_issued=lines_acked=1.
- Partial flush: 19 words, flush -> 3 writes:
  - addrs base+0/1/2
  - line 2 words 0-2 data, words 3-7 zero
  - done only after 3rd ack.
- Backpressure: hold wr_almfull for 40 cycles while feeding 48 words:
  - res_ready drops after 4 lines buffered
  - no request issued while almfull is held, apart from the single request already registered when almfull rose
  - 6 writes in order after release, no loss or duplication.
- Simultaneous flush + 8th word on same edge -> exactly one full line, no extra zero line; flush at word count 0 -> zero writes, done after outstanding acks.
- Error/restart: start during ACTIVE -> ignored, err=1; spurious wr_ack with issued==acked -> err=1, counter unchanged; reset mid-DRAIN -> IDLE, wr_valid 0 next cycle; new start clears err.

Source files
------------

// File: rtl/result_cl_writer_pkg.sv
// ---------------------------------------------------------------------------
// result_wr_pkg
// Shared types for the result cache-line write-back engine.
//   CL_WORDS    : 64-bit result words per 512-bit cache line
//   t_res_word  : one 64-bit bit-vector result word
//   t_line      : one 512-bit cache-line payload
//   t_line_idx  : line index, also carried in the request mdata field
//   t_wr_state  : engine state (IDLE, ACTIVE, DRAIN, DONE)
// ---------------------------------------------------------------------------
package result_wr_pkg;

   localparam int CL_WORDS   = 8;
   localparam int LINE_IDX_W = 16;

   typedef logic [63:0]             t_res_word;
   typedef logic [CL_WORDS*64-1:0]  t_line;
   typedef logic [LINE_IDX_W-1:0]   t_line_idx;

   typedef enum logic [1:0] {
      IDLE,
      ACTIVE,
      DRAIN,
      DONE
   } t_wr_state;

endpackage

// File: rtl/result_cl_writer_if.sv
// ---------------------------------------------------------------------------
// result_cl_writer_if
// Bundles the result-word stream coming from the filter and the channel-1
// write request/response signals going to the host.
//   res_valid/res_data/res_ready : result word handshake
//   wr_almfull/wr_ack            : c1TxAlmFull and write-response pulse
//   wr_valid/wr_addr/wr_mdata/wr_data : registered WrLine_I request
// The master modport is the write-back engine itself; the slave modport is
// its environment (result source plus host channel).
// ---------------------------------------------------------------------------
interface result_cl_writer_if #(
   parameter int ADDR_W = 42
);
   import result_wr_pkg::*;

   logic              res_valid;
   t_res_word         res_data;
   logic              res_ready;
   logic              wr_almfull;
   logic              wr_ack;
   logic              wr_valid;
   logic [ADDR_W-1:0] wr_addr;
   logic [15:0]       wr_mdata;
   t_line             wr_data;

   modport master (
      input  res_valid, res_data, wr_almfull, wr_ack,
      output res_ready, wr_valid, wr_addr, wr_mdata, wr_data
   );

   modport slave (
      output res_valid, res_data, wr_almfull, wr_ack,
      input  res_ready, wr_valid, wr_addr, wr_mdata, wr_data
   );

endinterface

// File: rtl/result_cl_writer_fifo.sv
// ---------------------------------------------------------------------------
// result_line_fifo
// Small synchronous FIFO holding completed cache lines together with their
// line index while the host channel is almost full.
//   clk, reset          : clock, synchronous active-high reset
//   i_push/i_pushLine/i_pushIdx : write side (ignored when full)
//   i_pop               : read side (ignored when empty)
//   o_popLine/o_popIdx  : head entry, valid whenever !o_empty
//   o_full/o_empty/o_count : occupancy
// ---------------------------------------------------------------------------
module result_line_fifo
   import result_wr_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     i_push,
   input  t_line                    i_pushLine,
   input  t_line_idx                i_pushIdx,
   input  logic                     i_pop,
   output t_line                    o_popLine,
   output t_line_idx                o_popIdx,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   t_line             r_lineMem [DEPTH];
   t_line_idx         r_idxMem  [DEPTH];
   logic [PTR_W-1:0]  r_wrPtr;
   logic [PTR_W-1:0]  r_rdPtr;
   logic [CNT_W-1:0]  r_count;
   logic              w_doPush;
   logic              w_doPop;

   assign o_full    = (r_count == CNT_W'(DEPTH));
   assign o_empty   = (r_count == '0);
   assign o_count   = r_count;
   assign o_popLine = r_lineMem[r_rdPtr];
   assign o_popIdx  = r_idxMem[r_rdPtr];
   assign w_doPush  = i_push && !o_full;
   assign w_doPop   = i_pop && !o_empty;

   // Storage is not reset: an entry is only ever read after it was written,
   // so clearing the pointers is enough to empty the FIFO.
   always_ff @(posedge clk) begin
      if (w_doPush) begin
         r_lineMem[r_wrPtr] <= i_pushLine;
         r_idxMem[r_wrPtr]  <= i_pushIdx;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two; the separate
   // counter distinguishes full from empty when the pointers are equal.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
      end else begin
         if (w_doPush) r_wrPtr <= r_wrPtr + PTR_W'(1);
         if (w_doPop)  r_rdPtr <= r_rdPtr + PTR_W'(1);
         case ({w_doPush, w_doPop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/result_cl_writer.sv
// ---------------------------------------------------------------------------
// result_cl_writer
// Packs 64-bit result words into 512-bit cache lines and issues one
// WrLine_I request per line to a host buffer, counting acknowledgements
// until every line has been committed.
//   clk, reset        : clock, synchronous active-high reset
//   i_start           : pulse, latch i_base_addr and begin a new run
//   i_base_addr       : host buffer cache-line address
//   i_flush           : pulse, no more results; emit partial line and drain
//   bus (master)      : result word stream in, channel-1 requests out
//   o_lines_issued    : requests sent since start
//   o_lines_acked     : acknowledgements received since start
//   o_busy / o_done   : run in progress / all lines committed
//   o_err             : sticky error (start while busy, ack underflow,
//                       issue counter wrap)
// ---------------------------------------------------------------------------
module result_cl_writer
   import result_wr_pkg::*;
#(
   parameter int ADDR_W       = 42,
   parameter int WORDS_PER_CL = CL_WORDS,
   parameter int CNT_W        = 16,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               i_start,
   input  logic [ADDR_W-1:0]  i_base_addr,
   input  logic               i_flush,
   result_cl_writer_if.master bus,
   output logic [CNT_W-1:0]   o_lines_issued,
   output logic [CNT_W-1:0]   o_lines_acked,
   output logic               o_busy,
   output logic               o_done,
   output logic               o_err
);

   localparam int WC_W = $clog2(WORDS_PER_CL);
   localparam int FC_W = $clog2(FIFO_DEPTH) + 1;

   t_wr_state          r_state;
   logic [ADDR_W-1:0]  r_base;
   t_line              r_pack;
   logic [WC_W-1:0]    r_wordCnt;
   t_line_idx          r_lineIdx;
   logic [CNT_W-1:0]   r_issued;
   logic [CNT_W-1:0]   r_acked;
   logic               r_err;
   logic               r_wrValid;
   logic [ADDR_W-1:0]  r_wrAddr;
   logic [15:0]        r_wrMdata;
   t_line              r_wrData;

   logic               w_busy;
   logic               w_resReady;
   logic               w_accept;
   logic               w_lineDone;
   logic               w_pushPart;
   logic               w_push;
   logic               w_pop;
   t_line              w_packNext;
   t_line              w_pushLine;
   t_line              w_popLine;
   t_line_idx          w_popIdx;
   logic               w_fifoFull;
   logic               w_fifoEmpty;
   logic [FC_W-1:0]    w_fifoCount;

   assign w_busy     = (r_state == ACTIVE) || (r_state == DRAIN);
   assign w_resReady = (r_state == ACTIVE) && (w_fifoCount < FC_W'(FIFO_DEPTH));
   assign w_accept   = bus.res_valid && w_resReady;
   assign w_lineDone = w_accept && (r_wordCnt == WC_W'(WORDS_PER_CL - 1));
   assign w_pushPart = (r_state == DRAIN) && (r_wordCnt != '0) && !w_fifoFull;
   assign w_push     = w_lineDone || w_pushPart;
   assign w_pushLine = w_lineDone ? w_packNext : r_pack;
   assign w_pop      = w_busy && !w_fifoEmpty && !bus.wr_almfull;

   assign bus.res_ready = w_resReady;
   assign bus.wr_valid  = r_wrValid;
   assign bus.wr_addr   = r_wrAddr;
   assign bus.wr_mdata  = r_wrMdata;
   assign bus.wr_data   = r_wrData;
   assign o_lines_issued = r_issued;
   assign o_lines_acked  = r_acked;
   assign o_busy         = w_busy;
   assign o_done         = (r_state == DONE);
   assign o_err          = r_err;

   // The line as it will look after this edge: the accepted word is dropped
   // into its slot so that the eighth word can be pushed straight to the
   // FIFO without first landing in the pack register.
   always_comb begin
      w_packNext = r_pack;
      for (int k = 0; k < WORDS_PER_CL; k++) begin
         if (w_accept && (r_wordCnt == WC_W'(k))) begin
            w_packNext[k*64 +: 64] = bus.res_data;
         end
      end
   end

   result_line_fifo #(
      .DEPTH      (FIFO_DEPTH)
   ) u_lineFifo (
      .clk        (clk),
      .reset      (reset),
      .i_push     (w_push),
      .i_pushLine (w_pushLine),
      .i_pushIdx  (r_lineIdx),
      .i_pop      (w_pop),
      .o_popLine  (w_popLine),
      .o_popIdx   (w_popIdx),
      .o_full     (w_fifoFull),
      .o_empty    (w_fifoEmpty),
      .o_count    (w_fifoCount)
   );

   // Main engine: request issue, ack counting, packing and the state machine
   // all live here. The start handling sits last so that clearing counters on
   // a new run overrides anything else happening on the same edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= IDLE;
         r_base    <= '0;
         r_pack    <= '0;
         r_wordCnt <= '0;
         r_lineIdx <= '0;
         r_issued  <= '0;
         r_acked   <= '0;
         r_err     <= 1'b0;
         r_wrValid <= 1'b0;
         r_wrAddr  <= '0;
         r_wrMdata <= '0;
         r_wrData  <= '0;
      end else begin
         r_wrValid <= w_pop;
         if (w_pop) begin
            r_wrAddr  <= r_base + ADDR_W'(w_popIdx);
            r_wrMdata <= w_popIdx;
            r_wrData  <= w_popLine;
            r_issued  <= r_issued + CNT_W'(1);
            if (&r_issued) r_err <= 1'b1;
         end

         if (bus.wr_ack) begin
            if (r_acked == r_issued) r_err   <= 1'b1;
            else                     r_acked <= r_acked + CNT_W'(1);
         end

         if (w_lineDone || w_pushPart) begin
            r_pack    <= '0;
            r_wordCnt <= '0;
         end else if (w_accept) begin
            r_pack    <= w_packNext;
            r_wordCnt <= r_wordCnt + WC_W'(1);
         end

         if (w_push) r_lineIdx <= r_lineIdx + 1'b1;

         case (r_state)
            IDLE, DONE: begin
               if (i_start) begin
                  r_state   <= ACTIVE;
                  r_base    <= i_base_addr;
                  r_pack    <= '0;
                  r_wordCnt <= '0;
                  r_lineIdx <= '0;
                  r_issued  <= '0;
                  r_acked   <= '0;
                  r_err     <= 1'b0;
               end
            end
            ACTIVE: begin
               if (i_start) r_err <= 1'b1;
               if (i_flush) r_state <= DRAIN;
            end
            DRAIN: begin
               if (i_start) r_err <= 1'b1;
               if ((r_wordCnt == '0) && w_fifoEmpty && !r_wrValid &&
                   (r_acked == r_issued)) begin
                  r_state <= DONE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_result_cl_writer.sv
// ---------------------------------------------------------------------------
// tb_result_cl_writer
// Drives random result words into result_cl_writer and checks every
// channel-1 write against lines predicted from the accepted word stream.
// ---------------------------------------------------------------------------
module tb_result_cl_writer;
   import result_wr_pkg::*;

   localparam int ADDR_W    = 42;
   localparam int CNT_W     = 16;
   localparam int ACK_DELAY = 5;

   typedef struct {
      logic [ADDR_W-1:0] addr;
      logic [15:0]       mdata;
      t_line             data;
   } t_expWr;

   logic              clk = 1'b0;
   logic              reset;
   logic              start;
   logic              flush;
   logic [ADDR_W-1:0] baseAddr;
   logic [CNT_W-1:0]  linesIssued;
   logic [CNT_W-1:0]  linesAcked;
   logic              busy;
   logic              done;
   logic              err;

   int                compared   = 0;
   int                mismatched = 0;
   int                cycle      = 0;
   int                writesSeen = 0;
   int                almWrites  = 0;
   int                wordsAccepted = 0;
   bit                almHeld    = 0;
   bit                spuriousReq = 0;

   t_expWr            expQ[$];
   t_res_word         modelWords[$];
   int                ackDue[$];
   logic [ADDR_W-1:0] modelBase;
   int                modelLineIdx;

   result_cl_writer_if #(.ADDR_W(ADDR_W)) bus();

   result_cl_writer #(
      .ADDR_W         (ADDR_W),
      .WORDS_PER_CL   (8),
      .CNT_W          (CNT_W),
      .FIFO_DEPTH     (4)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .i_start        (start),
      .i_base_addr    (baseAddr),
      .i_flush        (flush),
      .bus            (bus.master),
      .o_lines_issued (linesIssued),
      .o_lines_acked  (linesAcked),
      .o_busy         (busy),
      .o_done         (done),
      .o_err          (err)
   );

   // Free-running clock and a cycle counter used to time acknowledgements.
   always #5 clk = ~clk;
   always @(posedge clk) cycle <= cycle + 1;

   // Global time limit so a stuck design still ends the run.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [511:0] act,
                              input logic [511:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0h required %0h", name, act, exp);
      end
   endtask

   // Model: a line is the next eight accepted words (or fewer on flush, the
   // rest zero), written to base + running line number.
   task automatic emitLine();
      t_expWr e;
      e.data = '0;
      foreach (modelWords[i]) e.data[64*i +: 64] = modelWords[i];
      e.addr  = modelBase + ADDR_W'(modelLineIdx);
      e.mdata = 16'(modelLineIdx);
      expQ.push_back(e);
      modelLineIdx++;
      modelWords.delete();
   endtask

   // Monitor: every write request presented is compared with the head of the
   // expected queue, then acknowledged ACK_DELAY cycles later.
   always @(negedge clk) begin
      if (reset) begin
         ackDue.delete();
         bus.wr_ack = 1'b0;
      end else begin
         bus.wr_ack = 1'b0;
         if (bus.wr_valid) begin
            t_expWr e;
            writesSeen++;
            if (almHeld) almWrites++;
            ackDue.push_back(cycle + ACK_DELAY);
            checkOutput("write expected", expQ.size() != 0, 1'b1);
            if (expQ.size() != 0) begin
               e = expQ.pop_front();
               checkOutput("wr_addr", bus.wr_addr, e.addr);
               checkOutput("wr_mdata", bus.wr_mdata, e.mdata);
               checkOutput("wr_data", bus.wr_data, e.data);
            end
         end
         if (ackDue.size() != 0 && cycle >= ackDue[0]) begin
            void'(ackDue.pop_front());
            bus.wr_ack = 1'b1;
         end else if (spuriousReq) begin
            bus.wr_ack = 1'b1;
            spuriousReq = 0;
         end
      end
   end

   // All driver tasks start and end just after a rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic startRun(input logic [ADDR_W-1:0] base);
      baseAddr = base;
      start = 1'b1;
      tick();
      start = 1'b0;
      modelBase = base;
      modelLineIdx = 0;
      modelWords.delete();
   endtask

   task automatic flushRun();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      if (modelWords.size() != 0) emitLine();
   endtask

   // Offer one result word until it is accepted; optionally pulse flush on
   // the first offering edge.
   task automatic applyStimulus(input t_res_word w, input bit withFlush);
      bit accepted = 0;
      int tries = 0;
      bus.res_valid = 1'b1;
      bus.res_data  = w;
      flush = withFlush;
      while (!accepted && tries < 200) begin
         accepted = bus.res_ready;
         tick();
         flush = 1'b0;
         tries++;
      end
      bus.res_valid = 1'b0;
      checkOutput("word accepted", accepted, 1'b1);
      if (accepted) begin
         wordsAccepted++;
         modelWords.push_back(w);
         if (modelWords.size() == 8) emitLine();
         if (withFlush && modelWords.size() != 0) emitLine();
      end
   endtask

   task automatic waitDone(input string name, input int expLines);
      int n = 0;
      while (!done && n < 400) begin
         tick();
         n++;
      end
      checkOutput({name, " done"}, done, 1'b1);
      checkOutput({name, " lines_issued"}, linesIssued, expLines);
      checkOutput({name, " lines_acked"}, linesAcked, expLines);
      checkOutput({name, " pending writes"}, expQ.size(), 0);
   endtask

   function automatic t_res_word rndWord();
      return {$urandom(), $urandom()};
   endfunction

   function automatic logic [ADDR_W-1:0] rndAddr();
      logic [63:0] r;
      r = {$urandom(), $urandom()};
      return r[ADDR_W-1:0];
   endfunction

   initial begin
      int wordsBase;
      int seenBefore;
      reset = 1'b1;
      start = 1'b0;
      flush = 1'b0;
      baseAddr = '0;
      bus.res_valid  = 1'b0;
      bus.res_data   = '0;
      bus.wr_almfull = 1'b0;
      repeat (3) tick();

      checkOutput("reset busy", busy, 1'b0);
      checkOutput("reset done", done, 1'b0);
      checkOutput("reset err", err, 1'b0);
      checkOutput("reset wr_valid", bus.wr_valid, 1'b0);
      checkOutput("reset res_ready", bus.res_ready, 1'b0);
      checkOutput("reset lines_issued", linesIssued, 0);
      checkOutput("reset lines_acked", linesAcked, 0);
      reset = 1'b0;
      tick();

      $display("[TB] basic line");
      startRun(42'h1000);
      checkOutput("active busy", busy, 1'b1);
      for (int k = 0; k < 8; k++) applyStimulus(t_res_word'(k), 1'b0);
      flushRun();
      waitDone("basic", 1);

      $display("[TB] partial flush");
      startRun(rndAddr());
      for (int k = 0; k < 19; k++) applyStimulus(rndWord(), 1'b0);
      flushRun();
      checkOutput("partial not done yet", done, 1'b0);
      waitDone("partial", 3);

      $display("[TB] backpressure");
      startRun(rndAddr());
      wordsBase = wordsAccepted;
      fork
         begin
            bus.wr_almfull = 1'b1;
            almHeld = 1;
            repeat (40) tick();
            checkOutput("almfull res_ready", bus.res_ready, 1'b0);
            checkOutput("almfull words buffered", wordsAccepted - wordsBase, 32);
            checkOutput("almfull writes issued <= 1", almWrites <= 1, 1'b1);
            almHeld = 0;
            bus.wr_almfull = 1'b0;
         end
         begin
            for (int k = 0; k < 48; k++) applyStimulus(rndWord(), 1'b0);
         end
      join
      flushRun();
      waitDone("backpressure", 6);

      $display("[TB] flush with eighth word");
      startRun(rndAddr());
      for (int k = 0; k < 7; k++) applyStimulus(rndWord(), 1'b0);
      applyStimulus(rndWord(), 1'b1);
      waitDone("flush+word7", 1);

      startRun(rndAddr());
      for (int k = 0; k < 16; k++) applyStimulus(rndWord(), 1'b0);
      flushRun();
      waitDone("flush at count 0", 2);

      startRun(rndAddr());
      flushRun();
      waitDone("empty run", 0);

      $display("[TB] errors and restart");
      startRun(rndAddr());
      checkOutput("start clears err", err, 1'b0);
      for (int k = 0; k < 3; k++) applyStimulus(rndWord(), 1'b0);
      start = 1'b1;
      tick();
      start = 1'b0;
      checkOutput("start while active err", err, 1'b1);
      checkOutput("start while active still busy", busy, 1'b1);
      for (int k = 0; k < 5; k++) applyStimulus(rndWord(), 1'b0);
      flushRun();
      waitDone("ignored start", 1);

      startRun(rndAddr());
      checkOutput("restart clears err", err, 1'b0);
      flushRun();
      waitDone("pre-spurious", 0);
      spuriousReq = 1;
      repeat (4) tick();
      checkOutput("spurious ack err", err, 1'b1);
      checkOutput("spurious ack count", linesAcked, 0);

      startRun(rndAddr());
      checkOutput("restart after spurious err", err, 1'b0);
      bus.wr_almfull = 1'b1;
      for (int k = 0; k < 8; k++) applyStimulus(rndWord(), 1'b0);
      flushRun();
      checkOutput("drain busy", busy, 1'b1);
      seenBefore = writesSeen;
      reset = 1'b1;
      expQ.delete();
      modelWords.delete();
      tick();
      reset = 1'b0;
      checkOutput("reset mid-drain wr_valid", bus.wr_valid, 1'b0);
      checkOutput("reset mid-drain busy", busy, 1'b0);
      checkOutput("reset mid-drain done", done, 1'b0);
      bus.wr_almfull = 1'b0;
      repeat (20) tick();
      checkOutput("no writes after reset", writesSeen, seenBefore);

      startRun(rndAddr());
      for (int k = 0; k < 8; k++) applyStimulus(rndWord(), 1'b0);
      flushRun();
      waitDone("after reset", 1);
      checkOutput("final err", err, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
